pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 25 ++
 rtl/branch_cmp.sv | 35 +++
 rtl/pc_gen.sv | 108 ++++++++++
 tb/tb_pc_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC generator: transfer kinds,
// fetch FSM states and RISC-V branch funct3 codes.
package pc_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_JAL    = 2'b10,
    KIND_JALR   = 2'b11
  } ex_kind_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HALT  = 2'b10
  } pc_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator; reserved funct3 codes (010, 011) never take.
module branch_cmp
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // Select the comparison named by funct3
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, control-transfer redirect,
// misaligned-target halt and trap entry.
//
// state    | meaning
// ST_BOOT  | one idle cycle after reset, no request
// ST_FETCH | issuing fetches at PC, resolving transfers
// ST_HALT  | misaligned target seen, waiting for trap or reset
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h8000_0000),
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] link_addr,
  output logic            redirect,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  // IALIGN=2 only checks bit 0; IALIGN=4 checks bits 1:0
  localparam logic [1:0] ALIGN_MASK = (IALIGN == 2) ? 2'b01 : 2'b11;

  pc_state_e       state;
  logic [XLEN-1:0] pc;
  ex_kind_e        kind;
  logic            br_taken;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            tgt_misaligned;

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .funct3 (ex_funct3),
    .taken  (br_taken)
  );

  // Resolve the transfer: kind, taken decision, target and its alignment
  always_comb begin
    kind           = ex_kind_e'(ex_kind);
    jalr_sum       = ex_rs1 + ex_imm;
    target         = (kind == KIND_JALR) ? (jalr_sum & ~XLEN'(1)) : (ex_pc + ex_imm);
    tgt_misaligned = |(target[1:0] & ALIGN_MASK);
    taken          = ex_valid && ((kind == KIND_JAL) || (kind == KIND_JALR) ||
                                  ((kind == KIND_BRANCH) && br_taken));
  end

  assign req_valid = (state == ST_FETCH) && !stall;
  assign req_addr  = pc;
  assign link_addr = ex_pc + XLEN'(4);

  // Fetch FSM with PC, redirect and misalign bookkeeping; trap overrides all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_BOOT;
      pc            <= RESET_VEC;
      redirect      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      redirect <= 1'b0;
      if (trap_valid) begin
        state    <= ST_FETCH;
        pc       <= trap_vec;
        misalign <= 1'b0;
        redirect <= 1'b1;
      end else begin
        case (state)
          ST_BOOT: state <= ST_FETCH;
          ST_FETCH: begin
            if (taken) begin
              if (tgt_misaligned) begin
                misalign      <= 1'b1;
                misalign_addr <= target;
                state         <= ST_HALT;
              end else begin
                pc       <= target;
                redirect <= 1'b1;
              end
            end else if (req_valid && req_ready) begin
              pc <= pc + XLEN'(4);
            end
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a behavioural reference model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic [31:0] link_addr;
  logic        redirect;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        misalign;
  logic [31:0] misalign_addr;

  int checks = 0;
  int failures = 0;

  localparam int M_BOOT = 0, M_FETCH = 1, M_HALT = 2;
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_redirect;
  logic        m_mis;
  logic [31:0] m_mis_addr;

  pc_gen dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .stall(stall), .ex_valid(ex_valid), .ex_kind(ex_kind),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .link_addr(link_addr), .redirect(redirect),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .misalign(misalign),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic bit model_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return to_signed(a) < to_signed(b);
      3'd5: return to_signed(a) >= to_signed(b);
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 32'h8000_0000; m_redirect = 0; m_mis = 0; m_mis_addr = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic model_update();
    longint tgt;
    bit tk;
    if (rst) begin model_reset(); return; end
    m_redirect = 0;
    if (trap_valid) begin
      m_pc = trap_vec; m_mis = 0; m_mode = M_FETCH; m_redirect = 1; return;
    end
    if (m_mode == M_BOOT) begin m_mode = M_FETCH; return; end
    if (m_mode == M_HALT) return;
    tk = ex_valid && (ex_kind == 2'd2 || ex_kind == 2'd3 ||
                      (ex_kind == 2'd1 && model_cond(ex_funct3, ex_rs1, ex_rs2)));
    if (tk) begin
      if (ex_kind == 2'd3) begin
        tgt = (longint'(ex_rs1) + longint'(ex_imm)) % 64'd4294967296;
        tgt = tgt - (tgt % 2);
      end else begin
        tgt = (longint'(ex_pc) + longint'(ex_imm)) % 64'd4294967296;
      end
      if (tgt % 4 != 0) begin
        m_mis = 1; m_mis_addr = tgt[31:0]; m_mode = M_HALT;
      end else begin
        m_pc = tgt[31:0]; m_redirect = 1;
      end
    end else if (!stall && req_ready) begin
      m_pc = (m_pc == 32'hFFFF_FFFC) ? 32'h0 : m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; ex_valid = 0; ex_kind = 0; ex_funct3 = 0;
    ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0; trap_valid = 0; trap_vec = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_ready = 1; idle_inputs(); model_reset();
    #3;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", req_valid); end
    checks++; if (req_addr !== 32'h8000_0000) begin failures++; $display("FAIL reset_addr got=%h exp=80000000", req_addr); end
    checks++; if (redirect !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", redirect, misalign); end
    checks++; if (misalign_addr !== 32'h0) begin failures++; $display("FAIL reset_misaddr got=%h exp=00000000", misalign_addr); end
    tick(); tick();
  endtask

  // Release reset with ready held; BOOT cycle, then sequential addresses
  task automatic test_boot_seq();
    rst = 0; req_ready = 1; #1;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", req_valid); end
    tick();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin failures++; $display("FAIL boot_first got=%b/%h exp=1/80000000", req_valid, req_addr); end
    tick();
    checks++; if (req_addr !== 32'h8000_0004) begin failures++; $display("FAIL boot_second got=%h exp=80000004", req_addr); end
  endtask

  task automatic test_ready_low();
    req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004) begin failures++; $display("FAIL ready_low_hold got=%b/%h exp=1/80000004", req_valid, req_addr); end
    end
    req_ready = 1;
    tick();
    checks++; if (req_addr !== 32'h8000_0008) begin failures++; $display("FAIL ready_low_adv got=%h exp=80000008", req_addr); end
  endtask

  task automatic test_branch();
    logic [31:0] held;
    ex_valid = 1; ex_kind = 2'b01; ex_funct3 = 3'b100;
    ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 32'h1; ex_pc = 32'h8000_0010; ex_imm = 32'hFFFF_FFF0;
    tick();
    ex_valid = 0; #1;
    checks++; if (req_addr !== 32'h8000_0000 || redirect !== 1'b1) begin failures++; $display("FAIL blt_taken got=%h/%b exp=80000000/1", req_addr, redirect); end
    tick();
    checks++; if (redirect !== 1'b0 || req_addr !== 32'h8000_0004) begin failures++; $display("FAIL blt_pulse got=%b/%h exp=0/80000004", redirect, req_addr); end
    held = m_pc;
    req_ready = 0; ex_valid = 1; ex_funct3 = 3'b110;
    tick();
    ex_valid = 0; req_ready = 1; #1;
    checks++; if (req_addr !== held || redirect !== 1'b0) begin failures++; $display("FAIL bltu_not_taken got=%h/%b exp=%h/0", req_addr, redirect, held); end
  endtask

  task automatic test_misalign();
    ex_valid = 1; ex_kind = 2'b11; ex_rs1 = 32'h8000_0101; ex_imm = 32'h2;
    tick();
    ex_kind = 2'b10; ex_pc = 32'h8000_0000; ex_imm = 32'h40; #1;
    checks++; if (misalign !== 1'b1 || misalign_addr !== 32'h8000_0102) begin failures++; $display("FAIL jalr_misalign got=%b/%h exp=1/80000102", misalign, misalign_addr); end
    checks++; if (req_valid !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL halt_outputs got=%b/%b exp=0/0", req_valid, redirect); end
    tick();
    checks++; if (req_valid !== 1'b0 || misalign !== 1'b1) begin failures++; $display("FAIL halt_ignores_ex got=%b/%b exp=0/1", req_valid, misalign); end
    ex_valid = 0; trap_valid = 1; trap_vec = 32'h8000_0200;
    tick();
    trap_valid = 0; #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0200 || misalign !== 1'b0 || redirect !== 1'b1) begin failures++; $display("FAIL trap_resume got=%b/%h/%b/%b exp=1/80000200/0/1", req_valid, req_addr, misalign, redirect); end
  endtask

  task automatic test_jal_stall();
    stall = 1; req_ready = 1; ex_valid = 1; ex_kind = 2'b10; ex_pc = 32'h8000_0020; ex_imm = 32'h8; #1;
    checks++; if (link_addr !== 32'h8000_0024) begin failures++; $display("FAIL jal_link got=%h exp=80000024", link_addr); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", req_valid); end
    tick();
    stall = 0; ex_valid = 0; #1;
    checks++; if (req_addr !== 32'h8000_0028 || redirect !== 1'b1) begin failures++; $display("FAIL jal_target got=%h/%b exp=80000028/1", req_addr, redirect); end
  endtask

  task automatic test_wrap();
    trap_valid = 1; trap_vec = 32'hFFFF_FFFC; req_ready = 1;
    tick();
    trap_valid = 0; #1;
    checks++; if (req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", req_addr); end
    tick();
    checks++; if (req_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", req_addr); end
  endtask

  task automatic test_reset_mid_handshake();
    req_ready = 0; #2;
    rst = 1; model_reset(); #1;
    checks++; if (req_valid !== 1'b0 || req_addr !== 32'h8000_0000) begin failures++; $display("FAIL async_reset got=%b/%h exp=0/80000000", req_valid, req_addr); end
    tick();
    rst = 0; req_ready = 1; #1;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_boot got=%b exp=0", req_valid); end
    tick();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin failures++; $display("FAIL rst_first_req got=%b/%h exp=1/80000000", req_valid, req_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      if (rst) model_reset();
      req_ready  = $urandom_range(0, 3) != 0;
      stall      = $urandom_range(0, 4) == 0;
      ex_valid   = $urandom_range(0, 2) == 0;
      ex_kind    = 2'($urandom_range(0, 3));
      ex_funct3  = 3'($urandom_range(0, 7));
      ex_pc      = $urandom & 32'hFFFF_FFFC;
      ex_imm     = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ex_rs1     = $urandom;
      ex_rs2     = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
      trap_valid = (m_mode == M_HALT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      trap_vec   = $urandom & 32'hFFFF_FFFC;
      #1;
      checks++;
      if (req_valid !== ((m_mode == M_FETCH) && !stall) || req_addr !== m_pc ||
          link_addr !== ex_pc + 32'd4 || redirect !== m_redirect ||
          misalign !== m_mis || misalign_addr !== m_mis_addr) begin
        failures++;
        $display("FAIL random[%0d] got v=%b a=%h l=%h r=%b m=%b ma=%h exp v=%b a=%h l=%h r=%b m=%b ma=%h",
                 i, req_valid, req_addr, link_addr, redirect, misalign, misalign_addr,
                 (m_mode == M_FETCH) && !stall, m_pc, ex_pc + 32'd4, m_redirect, m_mis, m_mis_addr);
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_ready_low();
    test_branch();
    test_misalign();
    test_jal_stall();
    test_wrap();
    test_reset_mid_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
